// File: rtl/cdb_arbiter.sv
// Result-broadcast arbiter: per-source result queues drained round-robin onto NUM_CDB lanes.
// Lane outputs are registered; a result accepted in cycle N broadcasts in cycle N+2 when uncontended.
module cdb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int NUM_CDB = 2,
    parameter int DW      = 16,
    parameter int PW      = 5,
    parameter int TW      = 5,
    parameter int QDEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          freeze_back,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC-1:0]            src_nowb,
    input  logic [NUM_SRC-1:0][PW-1:0]    src_Pw,
    input  logic [NUM_SRC-1:0][TW-1:0]    src_tag,
    input  logic [NUM_SRC-1:0][DW-1:0]    src_data,
    output logic [NUM_CDB-1:0]            cdb_valid,
    output logic [NUM_CDB-1:0]            cdb_nowb,
    output logic [NUM_CDB-1:0][PW-1:0]    cdb_Pw,
    output logic [NUM_CDB-1:0][TW-1:0]    cdb_tag,
    output logic [NUM_CDB-1:0][DW-1:0]    cdb_data,
    output logic [NUM_CDB-1:0][1:0]       cdb_src
);

    // Handshake: a source entry is taken on a rising edge where src_valid && src_ready;
    // src_ready depends only on flush and the registered queue count, never on this cycle's pop.

    localparam int EW  = 1 + PW + TW + DW;
    localparam int QAW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW  = $clog2(QDEPTH + 1);

    typedef logic [EW-1:0] entry_t;

    entry_t           mem    [NUM_SRC][QDEPTH];
    entry_t           head   [NUM_SRC];
    logic [QAW-1:0]   wr_ptr [NUM_SRC];
    logic [QAW-1:0]   rd_ptr [NUM_SRC];
    logic [CW-1:0]    count  [NUM_SRC];
    logic [1:0]       rr;
    logic [1:0]       rr_next;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_CDB-1:0] lane_v;
    logic [1:0]       lane_src [NUM_CDB];

    function automatic logic [1:0] src_at(input logic [1:0] base, input int ofs);
        int t;
        t = int'(base) + ofs;
        if (t >= NUM_SRC) t = t - NUM_SRC;
        return t[1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = !flush && (count[i] < CW'(QDEPTH));
            push[i]      = src_valid[i] && src_ready[i];
            head[i]      = mem[i][rd_ptr[i]];
        end
    end

    // Scan from rr; the k-th non-empty source found takes lane k.
    always_comb begin
        int         taken;
        logic [1:0] s;
        taken   = 0;
        s       = 2'd0;
        grant   = '0;
        lane_v  = '0;
        rr_next = rr;
        for (int l = 0; l < NUM_CDB; l++) lane_src[l] = 2'd0;
        if (!freeze_back && !flush) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                s = src_at(rr, k);
                if (count[s] != '0 && taken < NUM_CDB) begin
                    grant[s] = 1'b1;
                    for (int l = 0; l < NUM_CDB; l++) begin
                        if (l == taken) begin
                            lane_v[l]   = 1'b1;
                            lane_src[l] = s;
                        end
                    end
                    taken   = taken + 1;
                    rr_next = src_at(s, 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= {src_nowb[i], src_Pw[i], src_tag[i], src_data[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr <= 2'd0;
        end else if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr <= 2'd0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i])  wr_ptr[i] <= wr_ptr[i] + QAW'(1);
                if (grant[i]) rd_ptr[i] <= rd_ptr[i] + QAW'(1);
                count[i] <= count[i] + CW'(push[i]) - CW'(grant[i]);
            end
            if (|grant) rr <= rr_next;
        end
    end

    // Idle lanes are driven to all-zero so downstream never sees stale fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid <= '0;
            cdb_nowb  <= '0;
            cdb_Pw    <= '0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else begin
            for (int l = 0; l < NUM_CDB; l++) begin
                if (lane_v[l]) begin
                    cdb_valid[l] <= 1'b1;
                    {cdb_nowb[l], cdb_Pw[l], cdb_tag[l], cdb_data[l]} <= head[lane_src[l]];
                    cdb_src[l]   <= lane_src[l];
                end else begin
                    cdb_valid[l] <= 1'b0;
                    cdb_nowb[l]  <= 1'b0;
                    cdb_Pw[l]    <= '0;
                    cdb_tag[l]   <= '0;
                    cdb_data[l]  <= '0;
                    cdb_src[l]   <= 2'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-source drivers, expected-broadcast queue, negedge monitor.
module tb_cdb_arbiter;
    localparam int NUM_SRC = 3;
    localparam int NUM_CDB = 2;
    localparam int DW = 16;
    localparam int PW = 5;
    localparam int TW = 5;
    localparam int QDEPTH = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic flush = 1'b0;
    logic freeze_back = 1'b0;
    logic [NUM_SRC-1:0]         src_valid = '0;
    logic [NUM_SRC-1:0]         src_ready;
    logic [NUM_SRC-1:0]         src_nowb = '0;
    logic [NUM_SRC-1:0][PW-1:0] src_Pw = '0;
    logic [NUM_SRC-1:0][TW-1:0] src_tag = '0;
    logic [NUM_SRC-1:0][DW-1:0] src_data = '0;
    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB-1:0]         cdb_nowb;
    logic [NUM_CDB-1:0][PW-1:0] cdb_Pw;
    logic [NUM_CDB-1:0][TW-1:0] cdb_tag;
    logic [NUM_CDB-1:0][DW-1:0] cdb_data;
    logic [NUM_CDB-1:0][1:0]    cdb_src;

    cdb_arbiter #(.NUM_SRC(NUM_SRC), .NUM_CDB(NUM_CDB), .DW(DW), .PW(PW), .TW(TW), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back),
        .src_valid(src_valid), .src_ready(src_ready), .src_nowb(src_nowb),
        .src_Pw(src_Pw), .src_tag(src_tag), .src_data(src_data),
        .cdb_valid(cdb_valid), .cdb_nowb(cdb_nowb), .cdb_Pw(cdb_Pw),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    int checks = 0;
    int fails = 0;
    // record: {lane, src[1:0], nowb, Pw[4:0], tag[4:0], data[15:0]}
    logic [29:0] exp_q[$];
    // driver item: {nowb, Pw[4:0], tag[4:0], data[15:0]}
    logic [26:0] drv_q [NUM_SRC][$];
    logic [NUM_SRC-1:0] acc = '0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic send(input int s, input logic nowb, input logic [4:0] pw,
                        input logic [4:0] tag, input logic [15:0] data);
        drv_q[s].push_back({nowb, pw, tag, data});
    endtask

    task automatic expect_bc(input int lane, input int src, input logic nowb, input logic [4:0] pw,
                             input logic [4:0] tag, input logic [15:0] data);
        exp_q.push_back({lane[0], src[1:0], nowb, pw, tag, data});
    endtask

    function automatic bit drv_busy();
        bit b = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) if (drv_q[s].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || drv_busy()) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || drv_busy()) begin
            fails++;
            $display("FAIL %s: %0d broadcasts outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
        end
        repeat (2) tick();
    endtask

    task automatic wait_accepted(input string name, input int budget);
        int n = 0;
        while (drv_busy() && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (drv_busy()) begin
            fails++;
            $display("FAIL %s: source items still unaccepted after %0d cycles, required none", name, budget);
        end
    endtask

    // driver: present queue heads, hold until accepted
    initial begin
        logic [26:0] cur;
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (acc[s] && drv_q[s].size() > 0) void'(drv_q[s].pop_front());
                if (drv_q[s].size() > 0) begin
                    cur = drv_q[s][0];
                    src_valid[s] = 1'b1;
                    src_nowb[s]  = cur[26];
                    src_Pw[s]    = cur[25:21];
                    src_tag[s]   = cur[20:16];
                    src_data[s]  = cur[15:0];
                end else begin
                    src_valid[s] = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            acc = src_valid & src_ready & {NUM_SRC{rst}};
        end
    end

    // monitor / scoreboard
    initial begin
        logic [29:0] got;
        logic [29:0] want;
        forever begin
            @(negedge clk);
            for (int l = 0; l < NUM_CDB; l++) begin
                if (cdb_valid[l]) begin
                    got = {l[0], cdb_src[l], cdb_nowb[l], cdb_Pw[l], cdb_tag[l], cdb_data[l]};
                    checks++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL lane%0d broadcast: got %h, required no broadcast", l, got);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            fails++;
                            $display("FAIL lane%0d broadcast: got %h, required %h", l, got, want);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL timeout: simulation did not finish within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int pat [3][2];
        int nxt [NUM_SRC];
        pat = '{'{0, 1}, '{2, 0}, '{1, 2}};

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("reset cdb_valid", 64'(cdb_valid), 64'd0);
        check("reset cdb fields", 64'({cdb_nowb, cdb_Pw, cdb_tag, cdb_src}), 64'd0);
        check("reset cdb_data", 64'(cdb_data), 64'd0);
        rst = 1'b1;
        tick();
        check("ready after reset", 64'(src_ready), 64'h7);

        // single ADD result, latency
        send(0, 1'b0, 5'd5, 5'd3, 16'h1234);
        expect_bc(0, 0, 1'b0, 5'd5, 5'd3, 16'h1234);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("single latency early", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        check("single latency lanes", 64'(cdb_valid), 64'h1);
        wait_idle("single drain", 20);

        // bring rr back to 0, then three simultaneous sources
        flush = 1'b1;
        @(negedge clk);
        check("ready during flush", 64'(src_ready), 64'd0);
        tick();
        flush = 1'b0;
        tick();
        send(0, 1'b0, 5'd1, 5'd11, 16'hA001);
        send(1, 1'b0, 5'd2, 5'd12, 16'hB002);
        send(2, 1'b0, 5'd3, 5'd13, 16'hC003);
        expect_bc(0, 0, 1'b0, 5'd1, 5'd11, 16'hA001);
        expect_bc(1, 1, 1'b0, 5'd2, 5'd12, 16'hB002);
        expect_bc(0, 2, 1'b0, 5'd3, 5'd13, 16'hC003);
        wait_idle("three sources", 20);
        // rr=0 puts ADD ahead of LS
        send(0, 1'b0, 5'd4, 5'd14, 16'hA004);
        send(2, 1'b0, 5'd6, 5'd16, 16'hC006);
        expect_bc(0, 0, 1'b0, 5'd4, 5'd14, 16'hA004);
        expect_bc(1, 2, 1'b0, 5'd6, 5'd16, 16'hC006);
        wait_idle("rr back at 0", 20);

        // saturation: six items per source, grant pairs rotate (0,1) (2,0) (1,2)
        for (int j = 0; j < 6; j++)
            for (int s = 0; s < NUM_SRC; s++)
                send(s, 1'b0, 5'(s * 8 + j), 5'(s * 8 + j + 1), 16'(s * 4096 + j));
        for (int s = 0; s < NUM_SRC; s++) nxt[s] = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                for (int l = 0; l < 2; l++) begin
                    expect_bc(l, pat[c][l], 1'b0, 5'(pat[c][l] * 8 + nxt[pat[c][l]]),
                              5'(pat[c][l] * 8 + nxt[pat[c][l]] + 1),
                              16'(pat[c][l] * 4096 + nxt[pat[c][l]]));
                    nxt[pat[c][l]]++;
                end
        wait_idle("saturation", 60);

        // freeze while ADD offers three results
        freeze_back = 1'b1;
        send(0, 1'b0, 5'd20, 5'd21, 16'hF001);
        send(0, 1'b0, 5'd22, 5'd23, 16'hF002);
        send(0, 1'b0, 5'd24, 5'd25, 16'hF003);
        expect_bc(0, 0, 1'b0, 5'd20, 5'd21, 16'hF001);
        expect_bc(0, 0, 1'b0, 5'd22, 5'd23, 16'hF002);
        expect_bc(0, 0, 1'b0, 5'd24, 5'd25, 16'hF003);
        @(negedge clk);
        @(negedge clk);
        check("freeze cycle1 cdb_valid", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        check("freeze cycle2 cdb_valid", 64'(cdb_valid), 64'd0);
        @(negedge clk);
        check("freeze cycle3 cdb_valid", 64'(cdb_valid), 64'd0);
        check("freeze full ready0", 64'(src_ready[0]), 64'd0);
        tick();
        freeze_back = 1'b0;
        @(negedge clk);
        check("freeze cycle4 cdb_valid", 64'(cdb_valid), 64'd0);
        check("release ready0 still full", 64'(src_ready[0]), 64'd0);
        @(negedge clk);
        check("release ready0 reopens", 64'(src_ready[0]), 64'd1);
        wait_idle("freeze drain", 20);

        // flush with queued entries and live lanes (rr=1 here)
        freeze_back = 1'b1;
        send(0, 1'b0, 5'd1, 5'd2, 16'h0A00);
        send(0, 1'b0, 5'd3, 5'd4, 16'h0A01);
        send(1, 1'b0, 5'd5, 5'd6, 16'h0B00);
        send(1, 1'b0, 5'd7, 5'd8, 16'h0B01);
        expect_bc(0, 1, 1'b0, 5'd5, 5'd6, 16'h0B00);
        expect_bc(1, 0, 1'b0, 5'd1, 5'd2, 16'h0A00);
        wait_accepted("flush fill", 20);
        freeze_back = 1'b0;
        @(negedge clk);
        check("pre-flush cdb_valid", 64'(cdb_valid), 64'd0);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush cycle lanes live", 64'(cdb_valid), 64'h3);
        check("flush cycle ready", 64'(src_ready), 64'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("post-flush cdb_valid", 64'(cdb_valid), 64'd0);
        check("post-flush ready", 64'(src_ready), 64'h7);
        send(0, 1'b0, 5'd9, 5'd10, 16'h0C00);
        send(1, 1'b0, 5'd11, 5'd12, 16'h0D00);
        expect_bc(0, 0, 1'b0, 5'd9, 5'd10, 16'h0C00);
        expect_bc(1, 1, 1'b0, 5'd11, 5'd12, 16'h0D00);
        wait_idle("post-flush rr=0", 20);

        // store result from LS
        send(2, 1'b1, 5'd9, 5'd7, 16'hBEEF);
        expect_bc(0, 2, 1'b1, 5'd9, 5'd7, 16'hBEEF);
        wait_idle("store nowb", 20);

        // async reset mid-burst
        send(0, 1'b0, 5'd1, 5'd1, 16'hD000);
        send(0, 1'b0, 5'd2, 5'd2, 16'hD001);
        send(0, 1'b0, 5'd3, 5'd3, 16'hD002);
        send(0, 1'b0, 5'd4, 5'd4, 16'hD003);
        expect_bc(0, 0, 1'b0, 5'd1, 5'd1, 16'hD000);
        expect_bc(0, 0, 1'b0, 5'd2, 5'd2, 16'hD001);
        expect_bc(0, 0, 1'b0, 5'd3, 5'd3, 16'hD002);
        expect_bc(0, 0, 1'b0, 5'd4, 5'd4, 16'hD003);
        repeat (4) tick();
        check("burst live before reset", 64'(cdb_valid), 64'h1);
        #1;
        rst = 1'b0;
        exp_q.delete();
        for (int s = 0; s < NUM_SRC; s++) drv_q[s].delete();
        #1;
        check("reset drops cdb_valid", 64'(cdb_valid), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("in reset cdb_valid", 64'(cdb_valid), 64'd0);
        check("in reset ready", 64'(src_ready), 64'h7);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("after reset no stale", 64'(cdb_valid), 64'd0);
        tick();
        send(0, 1'b0, 5'd13, 5'd14, 16'hE000);
        send(1, 1'b0, 5'd15, 5'd16, 16'hE001);
        expect_bc(0, 0, 1'b0, 5'd13, 5'd14, 16'hE000);
        expect_bc(1, 1, 1'b0, 5'd15, 5'd16, 16'hE001);
        wait_idle("after reset rr=0", 20);
        repeat (3) tick();
        check("no leftover expected broadcasts", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
